// File: rtl/ptg_intr_ctrl.sv
// Interrupt controller between the PTG interrupt generator and the CPU: edge-detected
// sticky W1C status with overflow, per-source enables, and a fixed-priority request/ack FSM.
module ptg_intr_ctrl #(
  parameter int HOLDOFF = 4,
  parameter int HW      = 4
) (
  input  logic       s_clk,
  input  logic       rst_n,
  input  logic       src_page_finish,
  input  logic       src_err_pkt_type,
  input  logic       src_err_img_type,
  input  logic       src_err_page_size,
  input  logic [3:0] reg_intr_en,
  input  logic       reg_clr_wr,
  input  logic [3:0] reg_clr_data,
  input  logic       cpu_ack,
  output logic       intr_req,
  output logic [1:0] intr_id,
  output logic [3:0] intr_status,
  output logic [3:0] intr_ovf,
  output logic       intr_busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_CLR, GAP} state_t;

  // A HOLDOFF of 0 behaves like 1, so the gap always lasts at least one cycle.
  localparam int              GapLoadInt = (HOLDOFF > 1) ? (HOLDOFF - 1) : 0;
  localparam logic [HW-1:0]   GapLoad    = GapLoadInt[HW-1:0];

  state_t        state_q, state_d;
  logic [1:0]    id_q, id_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic [3:0]    src_q;
  logic [3:0]    status_q, status_d;
  logic [3:0]    ovf_q, ovf_d;

  logic [3:0] srcVec;
  logic [3:0] evt;
  logic [3:0] clr;
  logic [3:0] evtClr;
  logic [3:0] pend;
  logic [1:0] prioId;

  assign srcVec = {src_err_page_size, src_err_img_type, src_err_pkt_type, src_page_finish};
  assign evt    = srcVec & ~src_q;
  assign clr    = reg_clr_wr ? reg_clr_data : 4'b0000;
  assign evtClr = evt & clr;
  assign pend   = status_q & reg_intr_en;

  // A new event always wins over a coincident clear; in that case overflow keeps its value.
  assign status_d = evt | (status_q & ~clr);
  assign ovf_d    = (evtClr & ovf_q)
                  | (~clr & evt & (ovf_q | status_q))
                  | (~evt & ovf_q & ~clr);

  always_comb begin
    prioId = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pend[i]) prioId = i[1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|pend) begin
          id_d    = prioId;
          state_d = REQ;
        end
      end
      REQ: begin
        // Ack takes precedence over a retraction seen in the same cycle.
        if (cpu_ack) begin
          state_d = WAIT_CLR;
        end else if (!status_q[id_q] || !reg_intr_en[id_q]) begin
          state_d = GAP;
          cnt_d   = GapLoad;
        end
      end
      WAIT_CLR: begin
        if (!status_q[id_q]) begin
          state_d = GAP;
          cnt_d   = GapLoad;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge s_clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      id_q     <= 2'd0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      src_q    <= 4'b0000;
      status_q <= 4'b0000;
      ovf_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      src_q    <= srcVec;
      status_q <= status_d;
      ovf_q    <= ovf_d;
    end
  end

  assign intr_req    = req_q;
  assign intr_id     = id_q;
  assign intr_status = status_q;
  assign intr_ovf    = ovf_q;
  assign intr_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_ptg_intr_ctrl.sv
// Directed bench for ptg_intr_ctrl: request ids and arrival cycles go through a scoreboard
// popped by a monitor on each intr_req rise; status, overflow and state are checked inline.
module tb_ptg_intr_ctrl;

  logic       s_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] srcVec = 4'b0000;
  logic [3:0] regIntrEn = 4'b0000;
  logic       regClrWr = 1'b0;
  logic [3:0] regClrData = 4'b0000;
  logic       cpuAck = 1'b0;
  logic       intrReq;
  logic [1:0] intrId;
  logic [3:0] intrStatus;
  logic [3:0] intrOvf;
  logic       intrBusy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int expId[$];
  int expCyc[$];
  logic prevReq = 1'b0;

  ptg_intr_ctrl #(.HOLDOFF(4), .HW(4)) dut (
    .s_clk             (s_clk),
    .rst_n             (rst_n),
    .src_page_finish   (srcVec[0]),
    .src_err_pkt_type  (srcVec[1]),
    .src_err_img_type  (srcVec[2]),
    .src_err_page_size (srcVec[3]),
    .reg_intr_en       (regIntrEn),
    .reg_clr_wr        (regClrWr),
    .reg_clr_data      (regClrData),
    .cpu_ack           (cpuAck),
    .intr_req          (intrReq),
    .intr_id           (intrId),
    .intr_status       (intrStatus),
    .intr_ovf          (intrOvf),
    .intr_busy         (intrBusy)
  );

  always #5 s_clk = ~s_clk;

  always @(posedge s_clk) cyc <= cyc + 1;

  // Monitor: every rising intr_req must match the oldest queued request (id and cycle).
  always @(negedge s_clk) begin
    if (intrReq && !prevReq) begin
      if (expId.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedReq: got id=%0d at cycle %0d, none expected", intrId, cyc);
      end else begin
        int eId;
        int eCyc;
        eId  = expId.pop_front();
        eCyc = expCyc.pop_front();
        checks += 2;
        if (int'(intrId) != eId) begin
          errors++;
          $display("[TB] FAIL reqId: got %0d expected %0d", intrId, eId);
        end
        if (cyc != eCyc) begin
          errors++;
          $display("[TB] FAIL reqCycle: got %0d expected %0d", cyc, eCyc);
        end
      end
    end
    prevReq = intrReq;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge s_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] src, input logic [3:0] en,
                               input logic clrWr, input logic [3:0] clrData, input logic ack);
    srcVec     = src;
    regIntrEn  = en;
    regClrWr   = clrWr;
    regClrData = clrData;
    cpuAck     = ack;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectReq(input int id, input int atCycle);
    expId.push_back(id);
    expCyc.push_back(atCycle);
  endtask

  // Called right after the request is visible: ack, clear, then wait out the gap.
  task automatic serviceAndClear(input logic [3:0] bits);
    applyStimulus(srcVec, regIntrEn, 1'b0, 4'b0000, 1'b1);
    tick(1);
    applyStimulus(srcVec, regIntrEn, 1'b1, bits, 1'b0);
    tick(1);
    applyStimulus(srcVec, regIntrEn, 1'b0, 4'b0000, 1'b0);
    tick(5);
    checkOutput("idleAfterService", {7'd0, intrBusy}, 8'd0);
  endtask

  initial begin
    int t;
    $display("[TB] starting ptg_intr_ctrl bench");
    tick(2);
    checkOutput("rstReq", {7'd0, intrReq}, 8'd0);
    checkOutput("rstId", {6'd0, intrId}, 8'd0);
    checkOutput("rstStatus", {4'd0, intrStatus}, 8'd0);
    checkOutput("rstOvf", {4'd0, intrOvf}, 8'd0);
    checkOutput("rstBusy", {7'd0, intrBusy}, 8'd0);
    rst_n = 1'b1;
    tick(1);

    // Single event on bit 1 with full ack/clear/gap sequence.
    t = cyc;
    applyStimulus(4'b0010, 4'hF, 1'b0, 4'b0000, 1'b0);
    expectReq(1, t + 2);
    tick(1);
    checkOutput("singleStatus", {4'd0, intrStatus}, 8'h02);
    checkOutput("singleReqLow", {7'd0, intrReq}, 8'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    tick(1);
    checkOutput("singleReq", {7'd0, intrReq}, 8'd1);
    checkOutput("singleId", {6'd0, intrId}, 8'd1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b1);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'b0010, 1'b0);
    checkOutput("ackDropsReq", {7'd0, intrReq}, 8'd0);
    checkOutput("waitClrBusy", {7'd0, intrBusy}, 8'd1);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    checkOutput("w1cStatus", {4'd0, intrStatus}, 8'h00);
    tick(4);
    checkOutput("gapLastBusy", {7'd0, intrBusy}, 8'd1);
    tick(1);
    checkOutput("gapDoneIdle", {7'd0, intrBusy}, 8'd0);

    // Priority: bits 0 and 3 together, bit 3 first, bit 0 after the gap.
    t = cyc;
    applyStimulus(4'b1001, 4'hF, 1'b0, 4'b0000, 1'b0);
    expectReq(3, t + 2);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    tick(1);
    checkOutput("prioFirstId", {6'd0, intrId}, 8'd3);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b1);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'b1000, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    checkOutput("prioRemaining", {4'd0, intrStatus}, 8'h01);
    expectReq(0, t + 10);
    tick(5);
    checkOutput("prioHoldoffLow", {7'd0, intrReq}, 8'd0);
    tick(1);
    checkOutput("prioSecondReq", {7'd0, intrReq}, 8'd1);
    checkOutput("prioSecondId", {6'd0, intrId}, 8'd0);
    serviceAndClear(4'b0001);

    // Masking: disabled source is recorded but not requested until enabled.
    applyStimulus(4'b0001, 4'b1110, 1'b0, 4'b0000, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 4'b1110, 1'b0, 4'b0000, 1'b0);
    checkOutput("maskStatus", {4'd0, intrStatus}, 8'h01);
    tick(2);
    checkOutput("maskNoReq", {7'd0, intrReq}, 8'd0);
    t = cyc;
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    expectReq(0, t + 1);
    tick(1);
    checkOutput("unmaskReq", {7'd0, intrReq}, 8'd1);
    serviceAndClear(4'b0001);

    // Retract: clearing bit 2 while requested, no ack.
    t = cyc;
    applyStimulus(4'b0100, 4'hF, 1'b0, 4'b0000, 1'b0);
    expectReq(2, t + 2);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    tick(1);
    checkOutput("retractId", {6'd0, intrId}, 8'd2);
    applyStimulus(4'b0000, 4'hF, 1'b1, 4'b0100, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    checkOutput("retractStatus", {4'd0, intrStatus}, 8'h00);
    checkOutput("retractStillReq", {7'd0, intrReq}, 8'd1);
    tick(1);
    checkOutput("retractReqLow", {7'd0, intrReq}, 8'd0);
    checkOutput("retractGapBusy", {7'd0, intrBusy}, 8'd1);
    tick(4);
    checkOutput("retractIdle", {7'd0, intrBusy}, 8'd0);

    // Collision: event and W1C on bit 1 in the same cycle, set wins.
    t = cyc;
    applyStimulus(4'b0010, 4'hF, 1'b1, 4'b0010, 1'b0);
    expectReq(1, t + 2);
    tick(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    checkOutput("collisionStatus", {4'd0, intrStatus}, 8'h02);
    tick(1);
    checkOutput("collisionId", {6'd0, intrId}, 8'd1);
    serviceAndClear(4'b0010);

    // Overflow on bit 0 with all sources disabled.
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    checkOutput("ovfFirstStatus", {4'd0, intrStatus}, 8'h01);
    checkOutput("ovfFirstOvf", {4'd0, intrOvf}, 8'h00);
    tick(1);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    checkOutput("ovfSet", {4'd0, intrOvf}, 8'h01);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    checkOutput("ovfClrStatus", {4'd0, intrStatus}, 8'h00);
    checkOutput("ovfClrOvf", {4'd0, intrOvf}, 8'h00);
    tick(2);
    checkOutput("ovfNoReq", {7'd0, intrReq}, 8'd0);

    // Reset while requesting, with the source held high through release.
    t = cyc;
    applyStimulus(4'b1000, 4'hF, 1'b0, 4'b0000, 1'b0);
    expectReq(3, t + 2);
    tick(2);
    checkOutput("preResetReq", {7'd0, intrReq}, 8'd1);
    rst_n = 1'b0;
    tick(1);
    checkOutput("midRstReq", {7'd0, intrReq}, 8'd0);
    checkOutput("midRstId", {6'd0, intrId}, 8'd0);
    checkOutput("midRstStatus", {4'd0, intrStatus}, 8'h00);
    checkOutput("midRstBusy", {7'd0, intrBusy}, 8'd0);
    t = cyc;
    rst_n = 1'b1;
    expectReq(3, t + 2);
    tick(1);
    checkOutput("postRstStatus", {4'd0, intrStatus}, 8'h08);
    tick(1);
    checkOutput("postRstReq", {7'd0, intrReq}, 8'd1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0);
    serviceAndClear(4'b1000);

    tick(3);
    checkOutput("scoreboardEmpty", 8'(expId.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
